// File: rtl/div_share_arbiter_if.sv
// Signal bundle between two divide requesters, the shared divider and the arbiter.
// The arbiter connects through the slave modport; the environment uses master.
interface div_share_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CLZ_W      = $clog2(DATA_WIDTH)
);
    logic                  r0_start;
    logic [DATA_WIDTH-1:0] r0_dividend;
    logic [DATA_WIDTH-1:0] r0_divisor;
    logic [CLZ_W-1:0]      r0_dividend_CLZ;
    logic [CLZ_W-1:0]      r0_divisor_CLZ;
    logic                  r0_divisor_is_zero;
    logic [DATA_WIDTH-1:0] r0_quotient;
    logic [DATA_WIDTH-1:0] r0_remainder;
    logic                  r0_done;

    logic                  r1_start;
    logic [DATA_WIDTH-1:0] r1_dividend;
    logic [DATA_WIDTH-1:0] r1_divisor;
    logic [CLZ_W-1:0]      r1_dividend_CLZ;
    logic [CLZ_W-1:0]      r1_divisor_CLZ;
    logic                  r1_divisor_is_zero;
    logic [DATA_WIDTH-1:0] r1_quotient;
    logic [DATA_WIDTH-1:0] r1_remainder;
    logic                  r1_done;

    logic                  div_start;
    logic [DATA_WIDTH-1:0] div_dividend;
    logic [DATA_WIDTH-1:0] div_divisor;
    logic [CLZ_W-1:0]      div_dividend_CLZ;
    logic [CLZ_W-1:0]      div_divisor_CLZ;
    logic                  div_divisor_is_zero;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;
    logic                  div_done;
    logic                  busy;

    modport slave (
        input  r0_start, r0_dividend, r0_divisor, r0_dividend_CLZ, r0_divisor_CLZ, r0_divisor_is_zero,
        input  r1_start, r1_dividend, r1_divisor, r1_dividend_CLZ, r1_divisor_CLZ, r1_divisor_is_zero,
        output r0_quotient, r0_remainder, r0_done,
        output r1_quotient, r1_remainder, r1_done,
        output div_start, div_dividend, div_divisor, div_dividend_CLZ, div_divisor_CLZ, div_divisor_is_zero,
        input  div_quotient, div_remainder, div_done,
        output busy
    );

    modport master (
        output r0_start, r0_dividend, r0_divisor, r0_dividend_CLZ, r0_divisor_CLZ, r0_divisor_is_zero,
        output r1_start, r1_dividend, r1_divisor, r1_dividend_CLZ, r1_divisor_CLZ, r1_divisor_is_zero,
        input  r0_quotient, r0_remainder, r0_done,
        input  r1_quotient, r1_remainder, r1_done,
        input  div_start, div_dividend, div_divisor, div_dividend_CLZ, div_divisor_CLZ, div_divisor_is_zero,
        output div_quotient, div_remainder, div_done,
        input  busy
    );
endinterface

// File: rtl/div_share_arbiter.sv
// Two-requester round-robin arbiter in front of one shared unsigned divider.
// Each requester has a one-deep operand buffer; results are registered per requester.
module div_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int CLZ_W      = $clog2(DATA_WIDTH)
) (
    input logic                clk,
    input logic                rst,
    div_share_arbiter_if.slave bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t state, next_state;

    logic [1:0]            pending;
    logic                  last_grant;
    logic                  owner;
    logic [DATA_WIDTH-1:0] buf_dividend     [2];
    logic [DATA_WIDTH-1:0] buf_divisor      [2];
    logic [CLZ_W-1:0]      buf_dividend_clz [2];
    logic [CLZ_W-1:0]      buf_divisor_clz  [2];
    logic [1:0]            buf_dz;

    logic [1:0]            start;
    logic [DATA_WIDTH-1:0] in_dividend     [2];
    logic [DATA_WIDTH-1:0] in_divisor      [2];
    logic [CLZ_W-1:0]      in_dividend_clz [2];
    logic [CLZ_W-1:0]      in_divisor_clz  [2];
    logic [1:0]            in_dz;

    logic [1:0]            accept;
    logic [1:0]            clear;
    logic                  grant;
    logic                  sel;
    logic                  complete;

    always_comb begin
        start              = {bus.r1_start, bus.r0_start};
        in_dividend[0]     = bus.r0_dividend;
        in_dividend[1]     = bus.r1_dividend;
        in_divisor[0]      = bus.r0_divisor;
        in_divisor[1]      = bus.r1_divisor;
        in_dividend_clz[0] = bus.r0_dividend_CLZ;
        in_dividend_clz[1] = bus.r1_dividend_CLZ;
        in_divisor_clz[0]  = bus.r0_divisor_CLZ;
        in_divisor_clz[1]  = bus.r1_divisor_CLZ;
        in_dz              = {bus.r1_divisor_is_zero, bus.r0_divisor_is_zero};
    end

    // A start is dropped while that requester already has a buffered or in-flight divide.
    always_comb begin
        accept = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            accept[n] = start[n] && !pending[n] && !(state == BUSY && owner == 1'(n));
        end
    end

    always_comb begin
        next_state              = state;
        grant                   = 1'b0;
        sel                     = 1'b0;
        complete                = 1'b0;
        bus.div_start           = 1'b0;
        bus.div_dividend        = '0;
        bus.div_divisor         = '0;
        bus.div_dividend_CLZ    = '0;
        bus.div_divisor_CLZ     = '0;
        bus.div_divisor_is_zero = 1'b0;
        bus.busy                = 1'b0;

        case (state)
            IDLE: begin
                if (pending != 2'b00 && !rst) begin
                    grant      = 1'b1;
                    sel        = (pending == 2'b11) ? ~last_grant : pending[1];
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (bus.div_done) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        if (grant) begin
            bus.div_start           = 1'b1;
            bus.div_dividend        = buf_dividend[sel];
            bus.div_divisor         = buf_divisor[sel];
            bus.div_dividend_CLZ    = buf_dividend_clz[sel];
            bus.div_divisor_CLZ     = buf_divisor_clz[sel];
            bus.div_divisor_is_zero = buf_dz[sel];
        end

        // The granting cycle counts as in flight so back-to-back divides keep busy high.
        bus.busy = ((state == BUSY) || grant) && !rst;
    end

    always_comb begin
        clear    = '0;
        clear[0] = grant && !sel;
        clear[1] = grant && sel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned n = 0; n < 2; n++) begin
            if (accept[n]) begin
                buf_dividend[n]     <= in_dividend[n];
                buf_divisor[n]      <= in_divisor[n];
                buf_dividend_clz[n] <= in_dividend_clz[n];
                buf_divisor_clz[n]  <= in_divisor_clz[n];
                buf_dz[n]           <= in_dz[n];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending          <= '0;
            last_grant       <= 1'b1;
            owner            <= 1'b0;
            bus.r0_quotient  <= '0;
            bus.r0_remainder <= '0;
            bus.r0_done      <= 1'b0;
            bus.r1_quotient  <= '0;
            bus.r1_remainder <= '0;
            bus.r1_done      <= 1'b0;
        end else begin
            bus.r0_done <= 1'b0;
            bus.r1_done <= 1'b0;
            pending     <= (pending & ~clear) | accept;
            if (grant) begin
                owner      <= sel;
                last_grant <= sel;
            end
            if (complete) begin
                if (owner) begin
                    bus.r1_quotient  <= bus.div_quotient;
                    bus.r1_remainder <= bus.div_remainder;
                    bus.r1_done      <= 1'b1;
                end else begin
                    bus.r0_quotient  <= bus.div_quotient;
                    bus.r0_remainder <= bus.div_remainder;
                    bus.r0_done      <= 1'b1;
                end
            end
        end
    end
endmodule
